// File: rtl/io_pkg.sv
// io_pkg: register offsets, UART_STATUS bit positions and the TX state type
// shared by io_responder and io_fifo.
package io_pkg;

  // IO page select bit and register offsets (IO_mem_addr[4:2])
  localparam int         IO_PAGE_BIT     = 22;
  localparam logic [2:0] REG_LEDS        = 3'd0;
  localparam logic [2:0] REG_UART_DATA   = 3'd1;
  localparam logic [2:0] REG_UART_STATUS = 3'd2;
  localparam logic [2:0] REG_CYCLES      = 3'd3;

  // UART_STATUS bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_COUNT   = 8;
  localparam int ST_COUNT_W = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: TX byte FIFO with push/pop/full/empty/count. A push while full is
// accepted only when a pop happens in the same cycle.
module io_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  // a depth-1 FIFO still needs a one-bit pointer that never leaves zero
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [2**AW];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // storage: written on accepted push only, contents not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped IO page (LEDS, UART TX, status, cycle counter).
// Build option: define IO_UART_FIFO_EN for a FIFO_DEPTH-entry TX FIFO;
// without it the UART uses a single holding register.
module io_responder
  import io_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [4:0]  LEDS,
  output logic        TXD
);

`ifdef IO_UART_FIFO_EN
  localparam int TXQ_DEPTH = FIFO_DEPTH;
`else
  // single holding register
  localparam int TXQ_DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif
  localparam int CW = $clog2(TXQ_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_DIV);

  logic                  wr_en;
  logic [2:0]            reg_sel;
  logic                  uart_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic [ST_COUNT_W-1:0] count_field;
  tx_state_t             state;
  logic [BW-1:0]         baud_cnt;
  logic                  baud_last;
  logic [2:0]            bit_cnt;
  logic [7:0]            tx_shift;
  logic                  overflow;
  logic                  ovf_evt;
  logic                  ovf_clr;
  logic [31:0]           cycles;
  logic [31:0]           status;
  logic                  unused_bits;

  assign wr_en       = IO_mem_wr & IO_mem_addr[IO_PAGE_BIT];
  assign reg_sel     = IO_mem_addr[4:2];
  assign uart_push   = wr_en & (reg_sel == REG_UART_DATA);
  assign baud_last   = (baud_cnt == BW'(BAUD_DIV - 1));
  assign fifo_pop    = ~fifo_empty & ((state == TX_IDLE) | ((state == TX_STOP) & baud_last));
  assign ovf_evt     = uart_push & fifo_full & ~fifo_pop;
  assign ovf_clr     = wr_en & (reg_sel == REG_UART_STATUS) & IO_mem_wdata[ST_OVF];
  assign count_field = ST_COUNT_W'(fifo_count);
  assign unused_bits = ^{IO_mem_addr[31:23], IO_mem_addr[21:5], IO_mem_addr[1:0],
                         IO_mem_wdata[31:8]};

  io_fifo #(
    .DEPTH  (TXQ_DEPTH),
    .DATA_W (8),
    .CNT_W  (CW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (uart_push),
    .pop    (fifo_pop),
    .din    (IO_mem_wdata[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // UART_STATUS word assembly
  always_comb begin
    status                          = '0;
    status[ST_FULL]                 = fifo_full;
    status[ST_BUSY]                 = (state != TX_IDLE);
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = overflow;
    status[ST_COUNT +: ST_COUNT_W]  = count_field;
  end

  // TX FSM; TXD is registered from the current state so it lags one edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      TXD      <= 1'b1;
    end else begin
      TXD <= (state == TX_START) ? 1'b0 : (state == TX_DATA) ? tx_shift[0] : 1'b1;
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            state    <= TX_START;
            baud_cnt <= '0;
          end
        end
        TX_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) state <= TX_STOP;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= fifo_empty ? TX_IDLE : TX_START;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // shift register: load on pop, shift LSB-first at the end of each data bit
  always_ff @(posedge clk) begin
    if (fifo_pop)                          tx_shift <= fifo_dout;
    else if ((state == TX_DATA) && baud_last) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // LED register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            LEDS <= '0;
    else if (wr_en && reg_sel == REG_LEDS) LEDS <= IO_mem_wdata[4:0];
  end

  // free-running cycle counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycles <= '0;
    else         cycles <= cycles + 32'd1;
  end

  // registered read mux, no read side effects
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      IO_mem_rdata <= '0;
    end else begin
      case (reg_sel)
        REG_LEDS:        IO_mem_rdata <= {27'd0, LEDS};
        REG_UART_STATUS: IO_mem_rdata <= status;
        REG_CYCLES:      IO_mem_rdata <= cycles;
        default:         IO_mem_rdata <= {31'd0, unused_bits & 1'b0};
      endcase
    end
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, meaning clock cycles per UART bit (100 MHz / 115200); legal minimum 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries (power of two).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 IO_mem_addr  input  32  byte address from core; bit 22 marks IO page; bits [4:2] select register.
REQ-007 IO_mem_wdata  input  32  store data.
REQ-008 IO_mem_wr  input  1  single-cycle write strobe.
REQ-009 IO_mem_rdata  output  32  read data for the selected register.
REQ-010 LEDS  output  5  LED register value.
REQ-011 TXD  output  1  UART serial output, idle high.

Function
REQ-012 SHALL accept a write only when IO_mem_wr=1 and IO_mem_addr[22]=1; register = IO_mem_addr[4:2].
REQ-013 SHALL decode offsets: 0 LEDS (RW, bits [4:0]); 1 UART_DATA (W, bits [7:0] pushed to FIFO); 2 UART_STATUS (R; W1C bit 3); 3 CYCLES (R, free-running 32-bit counter); 4-7 read 0, writes ignored.
REQ-014 UART_STATUS bits: [0] fifo_full, [1] tx_busy (FSM not IDLE), [2] fifo_empty, [3] overflow (sticky), [8+:5] fifo_count; other bits 0.
REQ-015 SHALL register IO_mem_rdata: value reflects address sampled on previous edge (valid in core WAIT_DATA cycle).
REQ-016 Reads SHALL have no side effects (no read strobe exists).
REQ-017 Write to UART_DATA while full and no pop that cycle SHALL drop the byte and set overflow.
REQ-018 Write while full coinciding with pop SHALL be accepted; count unchanged.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-020 TX FSM states IDLE, START, DATA, STOP; each non-IDLE bit lasts exactly BAUD_DIV cycles.
REQ-021 IDLE->START when FIFO non-empty: pop byte into shift register, TXD=0 from next edge.
REQ-022 START->DATA after BAUD_DIV; DATA sends 8 bits LSB first via 3-bit counter; DATA->STOP after bit 7; STOP drives TXD=1.
REQ-023 STOP->START directly if FIFO non-empty at STOP end (back-to-back frames, no idle gap), else ->IDLE.
REQ-024 Byte written at edge N with FSM IDLE and FIFO empty SHALL drive TXD low from edge N+2.
REQ-025 CYCLES SHALL increment every cycle, wrapping 0xFFFFFFFF->0.
REQ-026 Writing UART_STATUS with bit 3=1 SHALL clear overflow; a simultaneous overflow event SHALL win (flag stays set).

Reset
REQ-027 On resetn=0 SHALL asynchronously set: LEDS=0, TXD=1, IO_mem_rdata=0, FSM=IDLE, FIFO empty, overflow=0, CYCLES=0, baud counter=0.
REQ-028 Reset mid-frame SHALL abort the frame, TXD=1 immediately; FIFO contents are discarded.

Configuration
REQ-029 Macro IO_UART_FIFO_EN defined: FIFO of FIFO_DEPTH entries per REQ-017..019.
REQ-030 Macro IO_UART_FIFO_EN undefined: single holding register (depth 1), fifo_count in {0,1}; all other behaviour identical.

Structure
REQ-031 Package io_pkg SHALL hold register offset constants, status bit index constants and the TX state typedef.
REQ-032 FIFO SHALL be sub-module io_fifo (push/pop/full/empty/count, parameterised depth); TX FSM and register decode stay in io_responder.

Verification
REQ-033 BAUD_DIV=4: write 0x55 to UART_DATA -> TXD low from edge N+2, then 1,0,1,0,1,0,1,0, stop 1, each 4 cycles; frame 40 cycles.
REQ-034 Write 0x41,0x42 back-to-back -> two frames with no idle cycle between; status busy=1 throughout, empty=1 after second pop.
REQ-035 FIFO_DEPTH=16, FSM stalled by large BAUD_DIV: 18 writes -> first pops, 16 buffered, 18th dropped, overflow=1, full=1; write status 0x8 -> overflow=0.
REQ-036 Write 0x1F to LEDS then read offset 0 -> LEDS=0x1F, IO_mem_rdata=0x0000001F one cycle after address.
REQ-037 Deassert-assert resetn mid-DATA bit -> TXD=1 asynchronously, status reads 0x4 (empty only).
REQ-038 Write with IO_mem_addr[22]=0 to LEDS offset -> LEDS unchanged; read CYCLES twice 10 cycles apart -> difference 10.
